uart_periph: RTL

UART_PERIPH -- requirements
Module: uart_periph

---
 rtl/uart_pkg.sv | 44 ++++
 rtl/uart_rx_fifo.sv | 52 +++++
 rtl/uart_periph.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART peripheral: register offsets relative to
// BASE, CON bit positions and the TX/RX state encodings.
package uart_pkg;

    localparam logic [31:0] TXD_OFF = 32'h0000_0000;
    localparam logic [31:0] RXD_OFF = 32'h0000_0004;
    localparam logic [31:0] CON_OFF = 32'h0000_0008;

    localparam int CON_TX_IE    = 0;
    localparam int CON_RX_IE    = 1;
    localparam int CON_RX_VALID = 2;
    localparam int CON_TX_BUSY  = 3;
    localparam int CON_TX_DONE  = 4;
    localparam int CON_OVR      = 5;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    function automatic logic [31:0] pack_con(input logic ovr, input logic tx_done,
                                             input logic tx_busy, input logic rx_valid,
                                             input logic rx_ie, input logic tx_ie);
        logic [31:0] v;
        v               = '0;
        v[CON_OVR]      = ovr;
        v[CON_TX_DONE]  = tx_done;
        v[CON_TX_BUSY]  = tx_busy;
        v[CON_RX_VALID] = rx_valid;
        v[CON_RX_IE]    = rx_ie;
        v[CON_TX_IE]    = tx_ie;
        return v;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Four-entry receive FIFO for the UART peripheral (built only with
// UART_RX_FIFO_EN). The caller guarantees push is only asserted when there
// is room, counting a same-cycle pop as freeing a slot.
module uart_rx_fifo
(
    input  logic       clk,
    input  logic       reset,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic [2:0] count_o
);

    logic [7:0] mem_q [4];
    logic [1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0] count_q, count_d;

    // Pointer and occupancy next-state; pointers wrap naturally at 2 bits.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + 2'd1;
        if (pop_i)  rd_ptr_d = rd_ptr_q + 2'd1;
        if (push_i && !pop_i)      count_d = count_q + 3'd1;
        else if (pop_i && !push_i) count_d = count_q - 3'd1;
    end

    // Pointer/count registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Data storage; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/uart_periph.sv
// Memory-mapped UART: TXD/RXD/CON registers, 8N1 transmitter and receiver,
// level interrupt. Define UART_RX_FIFO_EN for a 4-deep RX FIFO; otherwise
// a single holding register is used.
//
// TX state | meaning
// IDLE     | line high, waiting for a TXD write
// START    | start bit (low)
// DATA     | 8 data bits, LSB first
// STOP     | stop bit (high); on exit tx_done is set
//
// RX state | meaning
// IDLE     | waiting for a falling edge on the synchronized line
// START    | half-bit wait, then re-check the line (glitch reject)
// DATA     | 8 samples, one per bit period
// STOP     | stop sample; high stores the byte, low discards it
module uart_periph
    import uart_pkg::*;
#(
    parameter int          CLK_DIV = 5208,
    parameter logic [31:0] BASE    = 32'h4000_0018
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq_out
);

    localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLK_DIV / 2 - 1);

    logic hit_txd, hit_rxd, hit_con;
    logic txd_wr, con_wr, con_rd, rxd_rd;
    assign hit_txd = (addr == BASE + TXD_OFF);
    assign hit_rxd = (addr == BASE + RXD_OFF);
    assign hit_con = (addr == BASE + CON_OFF);

    tx_state_e   tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d, tx_bit_nxt;
    logic        tx_line_q, tx_line_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic        tx_done_q, tx_done_d, tx_done_set;
    logic        tx_ie_q, tx_ie_d, rx_ie_q, rx_ie_d;
    logic        tx_busy;

    rx_state_e   rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [1:0]  rx_sync_q;
    logic        rx_prev_q, rx_s;
    logic        ovr_q, ovr_d;
    logic        rx_push_req, rx_push, rx_pop, rx_valid;
    logic [7:0]  rx_head;

    assign tx_busy    = (tx_state_q != TX_IDLE);
    assign txd_wr     = wr && hit_txd && !tx_busy;
    assign con_wr     = wr && hit_con;
    assign con_rd     = rd && hit_con;
    assign rxd_rd     = rd && hit_rxd;
    assign tx_bit_nxt = tx_bit_q + 3'd1;
    assign rx_s       = rx_sync_q[1];

    // TX FSM next-state and line level; the line is registered so it
    // changes on the accepting edge and resets high asynchronously.
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q;
        tx_bit_d    = tx_bit_q;
        tx_line_d   = tx_line_q;
        tx_done_set = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_line_d = 1'b1;
                if (txd_wr) begin
                    tx_state_d = TX_START;
                    tx_cnt_d   = '0;
                    tx_line_d  = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt_q == DIV_LAST) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_line_d  = tx_byte_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == DIV_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                        tx_line_d  = 1'b1;
                    end else begin
                        tx_bit_d  = tx_bit_nxt;
                        tx_line_d = tx_byte_q[tx_bit_nxt];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == DIV_LAST) begin
                    tx_state_d  = TX_IDLE;
                    tx_cnt_d    = '0;
                    tx_line_d   = 1'b1;
                    tx_done_set = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // RX FSM next-state: mid-bit sampling after a half-bit start check.
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_push_req = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_s) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == DIV_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == DIV_LAST) begin
                    rx_cnt_d    = '0;
                    rx_state_d  = RX_IDLE;
                    rx_push_req = rx_s;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

`ifdef UART_RX_FIFO_EN
    logic [2:0] fifo_count;

    assign rx_valid = (fifo_count != 3'd0);
    assign rx_pop   = rxd_rd && rx_valid;
    assign rx_push  = rx_push_req && ((fifo_count != 3'd4) || rx_pop);

    uart_rx_fifo u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (rx_push),
        .pop_i   (rx_pop),
        .data_i  (rx_shift_q),
        .data_o  (rx_head),
        .count_o (fifo_count)
    );
`else
    logic [7:0] rx_hold_q, rx_hold_d;
    logic       rx_valid_q, rx_valid_d;

    assign rx_valid = rx_valid_q;
    assign rx_pop   = rxd_rd && rx_valid_q;
    assign rx_push  = rx_push_req && (!rx_valid_q || rx_pop);
    assign rx_head  = rx_hold_q;

    // Holding register: a same-edge pop frees the slot for the new byte.
    always_comb begin
        rx_hold_d  = rx_hold_q;
        rx_valid_d = rx_valid_q;
        if (rx_push) begin
            rx_hold_d  = rx_shift_q;
            rx_valid_d = 1'b1;
        end else if (rx_pop) begin
            rx_valid_d = 1'b0;
        end
    end

    // Holding register state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_hold_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_hold_q  <= rx_hold_d;
            rx_valid_q <= rx_valid_d;
        end
    end
`endif

    // Control flags; a same-edge set beats the CON-read clear.
    always_comb begin
        tx_byte_d = txd_wr ? wdata[7:0] : tx_byte_q;
        tx_ie_d   = con_wr ? wdata[0] : tx_ie_q;
        rx_ie_d   = con_wr ? wdata[1] : rx_ie_q;
        tx_done_d = tx_done_q;
        if (txd_wr || con_rd) tx_done_d = 1'b0;
        if (tx_done_set)      tx_done_d = 1'b1;
        ovr_d = ovr_q;
        if (con_rd)                  ovr_d = 1'b0;
        if (rx_push_req && !rx_push) ovr_d = 1'b1;
    end

    // All peripheral state; the RX synchronizer resets to the idle level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_line_q  <= 1'b1;
            tx_byte_q  <= '0;
            tx_done_q  <= 1'b0;
            tx_ie_q    <= 1'b0;
            rx_ie_q    <= 1'b0;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_sync_q  <= 2'b11;
            rx_prev_q  <= 1'b1;
            ovr_q      <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_line_q  <= tx_line_d;
            tx_byte_q  <= tx_byte_d;
            tx_done_q  <= tx_done_d;
            tx_ie_q    <= tx_ie_d;
            rx_ie_q    <= rx_ie_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_sync_q  <= {rx_sync_q[0], uart_rx};
            rx_prev_q  <= rx_s;
            ovr_q      <= ovr_d;
        end
    end

    // Load-data mux; zero unless a mapped register is being read.
    always_comb begin
        rdata = '0;
        if (rd) begin
            if (hit_txd)      rdata = {24'b0, tx_byte_q};
            else if (hit_rxd) rdata = {24'b0, rx_head};
            else if (hit_con) rdata = pack_con(ovr_q, tx_done_q, tx_busy, rx_valid,
                                               rx_ie_q, tx_ie_q);
        end
    end

    assign uart_tx = tx_line_q;
    assign irq_out = (tx_ie_q & tx_done_q) | (rx_ie_q & rx_valid);

    logic unused_wdata;
    assign unused_wdata = &{1'b0, wdata[31:8]};

endmodule
